serial_word_assembler: RTL

//  Downstream consumer of the single-bit d-flop stage: samples its registered q output
//  as a serial bit stream and assembles WIDTH-bit words. Hunts for a sync strobe, shifts
//  in qualified bits, then presents each completed word on a valid/ready output register.

---
 rtl/serial_word_assembler.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_word_assembler.sv
// serial_word_assembler
//   Samples a registered single-bit stream and assembles WIDTH-bit words.
//   The block hunts for a sync strobe, then shifts in qualified bits. Each
//   completed word is presented on a valid/ready output register. A word that
//   cannot be loaded into that register is dropped and sets a sticky overflow.
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rstn         synchronous active-low reset
//   i_bit_in       serial data bit
//   i_bit_valid    i_bit_in is qualified this cycle
//   i_sync         start-of-word strobe; aborts any partial word
//   o_word_data    assembled word, stable while o_word_valid=1
//   o_word_valid   output register holds an undelivered word
//   i_word_ready   consumer accepts; transfer when valid & ready
//   o_bit_cnt      bits collected in the current partial word
//   o_hunting      1 while waiting for the first sync
//   o_overflow     sticky flag: a completed word was dropped
//   i_overflow_clr clears o_overflow (a new drop in the same cycle wins)
module serial_word_assembler #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_bit_in,
  input  logic                     i_bit_valid,
  input  logic                     i_sync,
  output logic [WIDTH-1:0]         o_word_data,
  output logic                     o_word_valid,
  input  logic                     i_word_ready,
  output logic [$clog2(WIDTH)-1:0] o_bit_cnt,
  output logic                     o_hunting,
  output logic                     o_overflow,
  input  logic                     i_overflow_clr
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {StHunt, StAssemble} state_e;

  state_e            r_state, w_state_d;
  logic [CntW-1:0]   r_cnt, w_cnt_d;
  logic [WIDTH-1:0]  r_shift, w_shift_d;
  logic [WIDTH-1:0]  r_data, w_data_d;
  logic              r_valid, w_valid_d;
  logic              r_ovf, w_ovf_d;

  logic [WIDTH-1:0]  w_base;
  logic [WIDTH-1:0]  w_shifted;
  logic              w_word_done;
  logic              w_load_ok;

  // A sync restarts the word, so the new bit shifts into an empty register.
  assign w_base    = i_sync ? '0 : r_shift;
  assign w_shifted = (MSB_FIRST != 0) ? {w_base[WIDTH-2:0], i_bit_in}
                                      : {i_bit_in, w_base[WIDTH-1:1]};
  assign w_load_ok = !r_valid || i_word_ready;

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_shift_d   = r_shift;
    w_word_done = 1'b0;
    if (i_sync) begin
      // Sync acts the same in both states: enter ASSEMBLE with an empty or one-bit word.
      w_state_d = StAssemble;
      w_cnt_d   = i_bit_valid ? CntW'(1) : '0;
      w_shift_d = i_bit_valid ? w_shifted : '0;
    end else begin
      unique case (r_state)
        StHunt: ;
        StAssemble: begin
          if (i_bit_valid) begin
            w_shift_d = w_shifted;
            if (r_cnt == CntLast) begin
              w_cnt_d     = '0;
              w_word_done = 1'b1;
            end else begin
              w_cnt_d = r_cnt + CntW'(1);
            end
          end
        end
        default: w_state_d = StHunt;
      endcase
    end
  end

  always_comb begin
    w_data_d  = r_data;
    w_valid_d = r_valid;
    w_ovf_d   = i_overflow_clr ? 1'b0 : r_ovf;
    if (w_word_done) begin
      if (w_load_ok) begin
        w_data_d  = w_shifted;
        w_valid_d = 1'b1;
      end else begin
        w_ovf_d = 1'b1;
      end
    end else if (r_valid && i_word_ready) begin
      w_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= StHunt;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_shift <= w_shift_d;
      r_data  <= w_data_d;
      r_valid <= w_valid_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign o_word_data  = r_data;
  assign o_word_valid = r_valid;
  assign o_bit_cnt    = r_cnt;
  assign o_hunting    = (r_state == StHunt);
  assign o_overflow   = r_ovf;

endmodule
